mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the sequential Y86-64 core, directly downstream of execute.
- Consumes icode, valE, valA and valP from fetch/execute, and performs the 8-byte little-endian data-memory read or write the instruction needs.
- Returns valM and the updated status to write-back/PC-update.
- Owns the data memory array.
- Models memory latency with a start/done handshake, so the sequential controller stalls until done.

Parameters:
- MEM_BYTES, 1024, data memory size in bytes; legal addresses 0..MEM_BYTES-1.
- WAIT_CYCLES, 2, extra wait states per memory access; range 0..15.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin operation; sampled only in IDLE.
- icode  input  4  instruction code.
- valE  input  64  ALU result; address for rmmovq, mrmovq, call, pushq.
- valA  input  64  write data for rmmovq and pushq; address for ret and popq.
- valP  input  64  write data for call.
- stat_in  input  3  incoming status: AOK=1, HLT=2, ADR=3, INS=4.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle completion pulse.
- valM  output  64  read data.
- dmem_error  output  1  address fault on the last operation.
- stat_out  output  3  resulting status.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - busy=0, done=0, valM=0, dmem_error=0, stat_out=1.
  - Memory array contents are not cleared.
  - A write still pending in ACCESS is abandoned and memory is not modified.
- Opcode classes:
  - Write: 4 (mem[valE]<=valA), 8 (mem[valE]<=valP), A (mem[valE]<=valA).
  - Read: 5 (valM<=mem[valE]), 9 (valM<=mem[valA]), B (valM<=mem[valA]).
  - All other icodes: no access.
- On start in IDLE, latch icode, address, write data and stat_in.
  - Memory op: go to ACCESS with counter=WAIT_CYCLES.
  - Non-memory op: go to DONE.
- start while busy=1 is ignored; latched values stay stable.
- ACCESS state:
  - If counter != 0, decrement the counter.
  - If counter == 0, perform the access on this edge and go to DONE.
- DONE state: done=1 for exactly one cycle, then return to IDLE.
- Latency, counted in edges after the edge that samples start:
  - Memory op: done is high after WAIT_CYCLES+2 edges.
  - Non-memory op: done is high after 1 edge.
- Access format:
  - 8 bytes, little-endian: byte addr holds bits [7:0], byte addr+7 holds bits [63:56].
  - Unaligned addresses are legal.
- Address check:
  - Fault when the unsigned 64-bit address > MEM_BYTES-8. Compare in full width with no wrap; 0xFFFF_FFFF_FFFF_FFF8 faults.
  - On fault: no write, valM=0, dmem_error=1, stat_out=3.
  - Otherwise: dmem_error=0 and stat_out=latched stat_in.
- Non-memory op: valM unchanged, dmem_error=0, stat_out=latched stat_in.
- Hold rules:
  - valM, dmem_error and stat_out update on the edge entering DONE.
  - All three hold until the next operation's DONE.
- Read-after-write: a read issued after a write's done observes the written data.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- Defined: an address with addr[2:0] != 0 is also a fault, with the same fault response as the range check.
- Undefined: unaligned accesses are legal; only the range check applies.

Test Plan:
- Reset: pulse rst asynchronously between edges -> busy=0, done=0, valM=0, dmem_error=0 and stat_out=1 immediately.
- Write/read, WAIT_CYCLES=2:
  - Write 0 at 0x18 first (icode 4, valE=0x18, valA=0).
  - icode 4, valE=0x10, valA=0x1122334455667788, start -> done after 4 edges.
  - icode 5, valE=0x10 -> valM=0x1122334455667788, stat_out=1.
  - icode 5, valE=0x11 -> valM=0x0011223344556677.
- Stack ops: icode A, valE=0x100, valA=0xDEAD; then icode B, valA=0x100 -> valM=0xDEAD. icode 8, valE=0x200, valP=0x37; then icode 9, valA=0x200 -> valM=0x37.
- Fault, MEM_BYTES=1024:
  - icode 4, valE=1017, valA=0xFF -> dmem_error=1, stat_out=3, valM=0.
  - Then icode 5, valE=1016 -> legal read, dmem_error=0, unchanged contents.
  - valE=0xFFFFFFFFFFFFFFF8 also faults.
- Non-memory op: icode 6, stat_in=1 -> done after 1 edge, valM unchanged. start held high while busy -> no second operation.
- Reset mid-operation: icode 4, valE=0x40, valA=0x55; assert rst during ACCESS counter=1 -> later icode 5, valE=0x40 returns the prior contents. With DMEM_ALIGN_CHECK_EN, icode 5, valE=0x11 -> dmem_error=1, stat_out=3.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage of the sequential Y86-64 core.
// Performs the 8-byte little-endian data-memory read or write an instruction needs.
// Returns valM and the updated status to write-back/PC-update.
// Memory latency is modelled with a start/done handshake: the controller stalls until done.
// Optional build macro: DMEM_ALIGN_CHECK_EN.
//   When defined, an access with addr[2:0] != 0 also faults.

module mem_stage #(
  parameter int unsigned MEM_BYTES   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  input  logic [2:0]  stat_in,
  output logic        busy,
  output logic        done,
  output logic [63:0] valM,
  output logic        dmem_error,
  output logic [2:0]  stat_out
);

  localparam int unsigned AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  // Highest legal start address of an 8-byte access
  localparam logic [63:0] MaxAddr = 64'(MEM_BYTES - 8);

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatAdr = 3'd3;

  localparam logic [3:0] IRmmovq = 4'h4;
  localparam logic [3:0] IMrmovq = 4'h5;
  localparam logic [3:0] ICall   = 4'h8;
  localparam logic [3:0] IRet    = 4'h9;
  localparam logic [3:0] IPushq  = 4'hA;
  localparam logic [3:0] IPopq   = 4'hB;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  function automatic logic is_write_op(input logic [3:0] ic);
    return (ic == IRmmovq) || (ic == ICall) || (ic == IPushq);
  endfunction

  function automatic logic is_read_op(input logic [3:0] ic);
    return (ic == IMrmovq) || (ic == IRet) || (ic == IPopq);
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  icode_q, icode_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [2:0]  stat_q, stat_d;
  logic [63:0] valm_q, valm_d;
  logic        err_q, err_d;
  logic [2:0]  stat_out_q, stat_out_d;

  // Data memory: not cleared by reset
  logic [7:0]  mem_q [MEM_BYTES];

  logic          fault;
  logic          access_fire;
  logic          mem_we;
  logic [AW-1:0] base;
  logic [63:0]   rdata;

  // Address fault detection on the latched address, full 64-bit compare
  always_comb begin
    fault = (addr_q > MaxAddr);
`ifdef DMEM_ALIGN_CHECK_EN
    fault = fault | (addr_q[2:0] != 3'd0);
`endif
  end

  // Access strobe, write enable and little-endian read assembly
  always_comb begin
    access_fire = (state_q == StAccess) && (cnt_q == 4'd0);
    mem_we      = access_fire && is_write_op(icode_q) && !fault;
    // A faulting address never indexes the array; keeps the read in range
    base        = fault ? '0 : addr_q[AW-1:0];
    rdata       = '0;
    for (int k = 0; k < 8; k++) begin
      rdata[8*k +: 8] = mem_q[base + AW'(k)];
    end
  end

  // Next-state logic: FSM, wait counter, operand latches and result registers
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    icode_d    = icode_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    stat_d     = stat_q;
    valm_d     = valm_q;
    err_d      = err_q;
    stat_out_d = stat_out_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          icode_d = icode;
          stat_d  = stat_in;
          // ret/popq address through valA, everything else through valE
          addr_d  = ((icode == IRet) || (icode == IPopq)) ? valA : valE;
          wdata_d = (icode == ICall) ? valP : valA;
          if (is_write_op(icode) || is_read_op(icode)) begin
            state_d = StAccess;
            cnt_d   = 4'(WAIT_CYCLES);
          end else begin
            // No access: results are final on the edge entering DONE
            state_d    = StDone;
            err_d      = 1'b0;
            stat_out_d = stat_in;
          end
        end
      end
      StAccess: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StDone;
          if (fault) begin
            valm_d     = '0;
            err_d      = 1'b1;
            stat_out_d = StatAdr;
          end else begin
            err_d      = 1'b0;
            stat_out_d = stat_q;
            if (is_read_op(icode_q)) begin
              valm_d = rdata;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and result registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      icode_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      stat_q     <= StatAok;
      valm_q     <= '0;
      err_q      <= 1'b0;
      stat_out_q <= StatAok;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      icode_q    <= icode_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      stat_q     <= stat_d;
      valm_q     <= valm_d;
      err_q      <= err_d;
      stat_out_q <= stat_out_d;
    end
  end

  // Memory array write; a reset in flight suppresses the pending store
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int k = 0; k < 8; k++) begin
        mem_q[base + AW'(k)] <= wdata_q[8*k +: 8];
      end
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign valM       = valm_q;
  assign dmem_error = err_q;
  assign stat_out   = stat_out_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized operations
// compared against a byte-array reference model.

module tb_mem_stage;

  localparam int unsigned MemBytes   = 1024;
  localparam int unsigned WaitCycles = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE;
  logic [63:0] valA;
  logic [63:0] valP;
  logic [2:0]  stat_in;
  logic        busy;
  logic        done;
  logic [63:0] valM;
  logic        dmem_error;
  logic [2:0]  stat_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0]  ref_mem [MemBytes];
  logic [63:0] ref_valm;
  logic        ref_err;
  logic [2:0]  ref_stat;

  mem_stage #(
    .MEM_BYTES  (MemBytes),
    .WAIT_CYCLES(WaitCycles)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .icode     (icode),
    .valE      (valE),
    .valA      (valA),
    .valP      (valP),
    .stat_in   (stat_in),
    .busy      (busy),
    .done      (done),
    .valM      (valM),
    .dmem_error(dmem_error),
    .stat_out  (stat_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, ".valM"}, valM, ref_valm);
    check_eq({tag, ".dmem_error"}, 64'(dmem_error), 64'(ref_err));
    check_eq({tag, ".stat_out"}, 64'(stat_out), 64'(ref_stat));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".busy"}, 64'(busy), 64'd0);
    check_eq({tag, ".done"}, 64'(done), 64'd0);
    check_eq({tag, ".valM"}, valM, 64'd0);
    check_eq({tag, ".dmem_error"}, 64'(dmem_error), 64'd0);
    check_eq({tag, ".stat_out"}, 64'(stat_out), 64'd1);
  endtask

  // Run one operation; model its effect and check latency and results
  task automatic run_op(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                        input logic [63:0] p, input logic [2:0] st, input bit hold_start);
    logic [63:0] addr;
    logic [63:0] wdata;
    bit          wr;
    bit          rd;
    bit          bad;
    int          lat;
    int          edges;
    int          idx;

    wr    = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
    rd    = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    addr  = ((ic == 4'h9) || (ic == 4'hB)) ? a : e;
    wdata = (ic == 4'h8) ? p : a;
    bad   = addr > 64'(MemBytes - 8);
`ifdef DMEM_ALIGN_CHECK_EN
    if (addr[2:0] != 3'd0) bad = 1'b1;
`endif
    if (wr || rd) begin
      lat = WaitCycles + 2;
      if (bad) begin
        ref_valm = '0;
        ref_err  = 1'b1;
        ref_stat = 3'd3;
      end else begin
        idx      = int'(addr);
        ref_err  = 1'b0;
        ref_stat = st;
        for (int k = 0; k < 8; k++) begin
          if (wr) ref_mem[idx + k] = wdata[8*k +: 8];
          else    ref_valm[8*k +: 8] = ref_mem[idx + k];
        end
      end
    end else begin
      lat      = 1;
      ref_err  = 1'b0;
      ref_stat = st;
    end

    @(negedge clk);
    icode   = ic;
    valE    = e;
    valA    = a;
    valP    = p;
    stat_in = st;
    start   = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    // Latched operands must not follow the inputs while busy
    start   = hold_start;
    icode   = 4'($urandom);
    valE    = rand64();
    valA    = rand64();
    valP    = rand64();
    stat_in = 3'($urandom);
    while (!done && edges < 64) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check_eq("latency", 64'(edges), 64'(lat));
    check_outputs("result");
    start = 1'b0;
    @(negedge clk);
    check_eq("idle_after_done", 64'({busy, done}), 64'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    ref_valm = '0;
    ref_err  = 1'b0;
    ref_stat = 3'd1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [63:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return 64'($urandom_range(0, MemBytes - 8)) & ~64'd7;
      1, 2:    return 64'($urandom_range(0, MemBytes - 8));
      3:       return 64'($urandom_range(MemBytes - 15, MemBytes - 1));
      4:       return rand64();
      default: return 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
    endcase
  endfunction

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    icode   = '0;
    valE    = '0;
    valA    = '0;
    valP    = '0;
    stat_in = 3'd1;
    ref_valm = '0;
    ref_err  = 1'b0;
    ref_stat = 3'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("initial_reset");
    rst = 1'b0;

    // Give every byte a known value
    for (int i = 0; i < int'(MemBytes / 8); i++) begin
      run_op(4'h4, 64'(i * 8), rand64(), 64'd0, 3'd1, 1'b0);
    end

    // Write then read back, aligned and unaligned
    run_op(4'h4, 64'h18, 64'd0, 64'd0, 3'd1, 1'b0);
    run_op(4'h4, 64'h10, 64'h1122_3344_5566_7788, 64'd0, 3'd1, 1'b0);
    run_op(4'h5, 64'h10, 64'd0, 64'd0, 3'd1, 1'b0);
    check_eq("rd_0x10", valM, 64'h1122_3344_5566_7788);
    check_eq("rd_0x10.stat", 64'(stat_out), 64'd1);
    run_op(4'h5, 64'h11, 64'd0, 64'd0, 3'd1, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
    check_eq("rd_0x11.align_err", 64'(dmem_error), 64'd1);
    check_eq("rd_0x11.align_stat", 64'(stat_out), 64'd3);
`else
    check_eq("rd_0x11", valM, 64'h0011_2233_4455_6677);
`endif

    // Stack operations
    run_op(4'hA, 64'h100, 64'hDEAD, 64'd0, 3'd1, 1'b0);
    run_op(4'hB, 64'd0, 64'h100, 64'd0, 3'd1, 1'b0);
    check_eq("popq", valM, 64'hDEAD);
    run_op(4'h8, 64'h200, 64'd0, 64'h37, 3'd1, 1'b0);
    run_op(4'h9, 64'd0, 64'h200, 64'd0, 3'd1, 1'b0);
    check_eq("ret", valM, 64'h37);

    // Range faults
    run_op(4'h4, 64'd1017, 64'hFF, 64'd0, 3'd1, 1'b0);
    check_eq("fault_1017.err", 64'(dmem_error), 64'd1);
    check_eq("fault_1017.stat", 64'(stat_out), 64'd3);
    check_eq("fault_1017.valM", valM, 64'd0);
    run_op(4'h5, 64'd1016, 64'd0, 64'd0, 3'd1, 1'b0);
    check_eq("rd_1016.err", 64'(dmem_error), 64'd0);
    run_op(4'h5, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0, 3'd1, 1'b0);
    check_eq("fault_wrap.err", 64'(dmem_error), 64'd1);

    // Non-memory op with start held high while busy
    run_op(4'h5, 64'h10, 64'd0, 64'd0, 3'd1, 1'b0);
    run_op(4'h6, 64'h10, 64'd0, 64'd0, 3'd1, 1'b1);
    check_eq("nonmem.valM_held", valM, 64'h1122_3344_5566_7788);

    // Asynchronous reset between edges
    pulse_reset();

    // Reset during ACCESS with counter at 1 abandons the write
    @(negedge clk);
    icode   = 4'h4;
    valE    = 64'h40;
    valA    = 64'h55;
    stat_in = 3'd1;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    ref_valm = '0;
    ref_err  = 1'b0;
    ref_stat = 3'd1;
    check_reset_outputs("reset_mid_access");
    @(negedge clk);
    rst = 1'b0;
    run_op(4'h5, 64'h40, 64'd0, 64'd0, 3'd1, 1'b0);

    // Randomized operations
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 24) == 0) pulse_reset();
      run_op(4'($urandom), pick_addr(), ($urandom_range(0, 1) != 0) ? pick_addr() : rand64(),
             rand64(), 3'($urandom_range(1, 4)), bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
